// File: rtl/day3_pkg.sv
// Shared constants and byte classification for the day-3 joltage datapath.
package day3_pkg;

  localparam logic [7:0] ASCII_NL = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;
  localparam int         DIGIT_W  = 4;
  localparam int         JOLT_W   = 7;

  typedef enum logic [1:0] {
    BC_DIGIT,
    BC_NL,
    BC_OTHER
  } byte_class_e;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_0) && (b <= ASCII_9);
  endfunction

  function automatic byte_class_e classify(input logic [7:0] b);
    if (is_digit(b))        return BC_DIGIT;
    else if (b == ASCII_NL) return BC_NL;
    else                    return BC_OTHER;
  endfunction

endpackage

// File: rtl/jolt_pair_update.sv
// Combinational step of the best-pair scan: folds one new digit into the
// running (max leading digit, best two-digit value) pair.
module jolt_pair_update
  import day3_pkg::*;
(
  input  logic              have_first,
  input  logic [DIGIT_W-1:0] max_d,
  input  logic [JOLT_W-1:0]  best,
  input  logic [DIGIT_W-1:0] d,
  output logic [DIGIT_W-1:0] next_max_d,
  output logic [JOLT_W-1:0]  next_best
);

  logic [JOLT_W-1:0] md_ext;
  logic [JOLT_W-1:0] cand;

  // 10*max_d + d built from shifts; worst case 99 fits in JOLT_W bits.
  always_comb begin
    md_ext     = JOLT_W'(max_d);
    cand       = (md_ext << 3) + (md_ext << 1) + JOLT_W'(d);
    next_best  = best;
    next_max_d = d;
    if (have_first) begin
      if (cand > best) next_best = cand;
      next_max_d = (d > max_d) ? d : max_d;
    end
  end

endmodule

// File: rtl/bank_joltage_scan.sv
// Streaming scanner: turns an ASCII stream of battery banks (one per line)
// into one best two-digit joltage per bank, through a 1-deep output register.
module bank_joltage_scan
  import day3_pkg::*;
#(
  parameter int OUT_W = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      bank_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  byte_class_e        cls;
  logic               accept;
  logic               dig_acc;
  logic               nl_acc;
  logic               load;
  logic               out_hs;
  logic [DIGIT_W-1:0] d;

  logic               have_first;
  logic [DIGIT_W-1:0] max_d;
  logic [JOLT_W-1:0]  best;
  logic [CNT_W-1:0]   dcnt;
  logic [DIGIT_W-1:0] next_max_d;
  logic [JOLT_W-1:0]  next_best;

  // Byte classification and handshake decode; one ready rule for every byte
  // class keeps results in stream order.
  always_comb begin
    cls      = classify(in_data);
    in_ready = ~out_valid | out_ready;
    accept   = in_valid & in_ready;
    dig_acc  = accept && (cls == BC_DIGIT);
    nl_acc   = accept && (cls == BC_NL);
    load     = nl_acc && (dcnt != '0);
    out_hs   = out_valid & out_ready;
    d        = in_data[DIGIT_W-1:0];
  end

  jolt_pair_update u_update (
    .have_first (have_first),
    .max_d      (max_d),
    .best       (best),
    .d          (d),
    .next_max_d (next_max_d),
    .next_best  (next_best)
  );

  // Per-bank scan state: folds digits in, clears when a result is loaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      have_first <= 1'b0;
      max_d      <= '0;
      best       <= '0;
      dcnt       <= '0;
    end else if (load) begin
      have_first <= 1'b0;
      max_d      <= '0;
      best       <= '0;
      dcnt       <= '0;
    end else if (dig_acc) begin
      have_first <= 1'b1;
      max_d      <= next_max_d;
      best       <= next_best;
      dcnt       <= sat_inc(dcnt);
    end
  end

  // Output skid register: reload wins over drain so back-to-back results
  // leave no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      if (dcnt == CNT_W'(1)) begin
        out_data <= '0;
        out_err  <= 1'b1;
      end else begin
        out_data <= {{(OUT_W-JOLT_W){1'b0}}, best};
        out_err  <= 1'b0;
      end
    end else if (out_hs) begin
      out_valid <= 1'b0;
    end
  end

  // Count of results taken downstream; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst)         bank_cnt <= '0;
    else if (out_hs) bank_cnt <= bank_cnt + 16'd1;
  end

endmodule
